// File: rtl/cache_fill_ctrl.sv
// cache_fill_ctrl: single-outstanding miss handler between a client, a direct-mapped cache and an Avalon-MM read master
module cache_fill_ctrl #(
  parameter int SIZE_BLOCK = 32,
  parameter int BIT_TOTAL  = 24,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [BIT_TOTAL-1:0]  req_addr,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [SIZE_BLOCK-1:0] resp_data,
  output logic                  resp_hit,
  output logic                  c_en,
  output logic                  c_wrt,
  output logic [BIT_TOTAL-1:0]  c_addr,
  output logic [SIZE_BLOCK-1:0] c_wdata,
  input  logic [SIZE_BLOCK-1:0] c_rdata,
  input  logic                  c_success,
  output logic                  avm_read,
  output logic [BIT_TOTAL-1:0]  avm_address,
  input  logic                  avm_waitrequest,
  input  logic [SIZE_BLOCK-1:0] avm_readdata,
  input  logic                  avm_readdatavalid,
  output logic [CNT_W-1:0]      hit_count,
  output logic [CNT_W-1:0]      miss_count
);
  typedef enum logic [2:0] {IDLE, LOOKUP, CHECK, MEM_REQ, MEM_WAIT, FILL, RESP} state_t;
  state_t state_q, state_d;
  logic [BIT_TOTAL-1:0] addr_q, addr_d;
  logic [SIZE_BLOCK-1:0] resp_data_q, resp_data_d, c_wdata_q, c_wdata_d;
  logic resp_hit_q, resp_hit_d;
  logic [CNT_W-1:0] hit_q, hit_d, miss_q, miss_d;
  logic req_ready_q, resp_valid_q, c_en_q, c_wrt_q, avm_read_q;
  logic [BIT_TOTAL-1:0] c_addr_q, avm_address_q;
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    resp_data_d = resp_data_q;
    resp_hit_d = resp_hit_q;
    c_wdata_d = c_wdata_q;
    hit_d = hit_q;
    miss_d = miss_q;
    case (state_q)
      IDLE: if (req_valid) begin
        addr_d = req_addr;
        state_d = LOOKUP;
      end
      LOOKUP: state_d = CHECK;
      CHECK: if (c_success) begin
        resp_data_d = c_rdata;
        resp_hit_d = 1'b1;
        hit_d = &hit_q ? hit_q : hit_q + CNT_W'(1);
        state_d = RESP;
      end else begin
        miss_d = &miss_q ? miss_q : miss_q + CNT_W'(1);
        state_d = MEM_REQ;
      end
      MEM_REQ: state_d = avm_waitrequest ? MEM_REQ : MEM_WAIT;
      MEM_WAIT: if (avm_readdatavalid) begin
        resp_data_d = avm_readdata;
        c_wdata_d = avm_readdata;
        resp_hit_d = 1'b0;
        state_d = FILL;
      end
      FILL: state_d = RESP;
      RESP: state_d = resp_ready ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
  end
  // Strobes are registered from the next state so they line up with the state they belong to.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q <= '0;
      resp_data_q <= '0;
      resp_hit_q <= 1'b0;
      c_wdata_q <= '0;
      hit_q <= '0;
      miss_q <= '0;
      req_ready_q <= 1'b1;
      resp_valid_q <= 1'b0;
      c_en_q <= 1'b0;
      c_wrt_q <= 1'b0;
      avm_read_q <= 1'b0;
      c_addr_q <= '0;
      avm_address_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      resp_data_q <= resp_data_d;
      resp_hit_q <= resp_hit_d;
      c_wdata_q <= c_wdata_d;
      hit_q <= hit_d;
      miss_q <= miss_d;
      req_ready_q <= state_d == IDLE;
      resp_valid_q <= state_d == RESP;
      c_en_q <= state_d == LOOKUP || state_d == FILL;
      c_wrt_q <= state_d == FILL;
      avm_read_q <= state_d == MEM_REQ;
      c_addr_q <= (state_d == LOOKUP || state_d == FILL) ? addr_d : c_addr_q;
      avm_address_q <= state_d == MEM_REQ ? addr_d : avm_address_q;
    end
  end
  assign req_ready = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_data = resp_data_q;
  assign resp_hit = resp_hit_q;
  assign c_en = c_en_q;
  assign c_wrt = c_wrt_q;
  assign c_addr = c_addr_q;
  assign c_wdata = c_wdata_q;
  assign avm_read = avm_read_q;
  assign avm_address = avm_address_q;
  assign hit_count = hit_q;
  assign miss_count = miss_q;
endmodule

// File: doc/cache_fill_ctrl.md
# cache_fill_ctrl

Miss-handling front end for the read-only direct-mapped cache (`cache_ro`). It accepts word-read requests from a client (ray/triangle fetch stage) over a valid/ready handshake. It looks each address up in the cache and, on a miss, fetches the word from external memory over an Avalon-MM pipelined read master. It then writes the fetched word into the cache and returns it to the client. The cache stays a separate instance; this block drives its `en/wrt/i_addr/i_data` port group and reads back `o_data/o_success`.

## Interface
Parameters:
- `SIZE_BLOCK`, 32, data word width in bits; must match the cache.
- `BIT_TOTAL`, 24, word-address width; must match the cache.
- `CNT_W`, 32, width of the hit/miss statistics counters.

Ports:
- `clk`  in  1  sole clock; everything is on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  1  client request valid.
- `req_ready`  out  1  block can accept a request.
- `req_addr`  in  BIT_TOTAL  word address.
- `resp_valid`  out  1  response valid.
- `resp_ready`  in  1  client accepts response.
- `resp_data`  out  SIZE_BLOCK  returned word.
- `resp_hit`  out  1  1 = served from cache, 0 = served after fill.
- `c_en`, `c_wrt`  out  1 each  cache enable and write select.
- `c_addr`  out  BIT_TOTAL  cache address.
- `c_wdata`  out  SIZE_BLOCK  cache write data.
- `c_rdata`  in  SIZE_BLOCK  cache `o_data`.
- `c_success`  in  1  cache `o_success` (hit).
- `avm_read`  out  1  memory read strobe.
- `avm_address`  out  BIT_TOTAL  memory word address.
- `avm_waitrequest`  in  1  memory stall.
- `avm_readdata`  in  SIZE_BLOCK  memory read data.
- `avm_readdatavalid`  in  1  memory read data valid.
- `hit_count`, `miss_count`  out  CNT_W each  saturating statistics counters.

## Operation
- One request in flight; no pipelining between requests.
- FSM states: IDLE, LOOKUP, CHECK, MEM_REQ, MEM_WAIT, FILL, RESP.
- All outputs are registered. Reset value of every output is 0, except `req_ready` = 1, which follows state IDLE.
- IDLE: `req_ready` = 1. On `req_valid` the block latches `req_addr` into `addr_q` and moves to LOOKUP.
- LOOKUP (1 cycle): `c_en` = 1, `c_wrt` = 0, `c_addr` = `addr_q`. The cache samples at the end of this cycle, and its result is visible in CHECK.
- CHECK (1 cycle):
  - If `c_success` = 1: latch `c_rdata` into `resp_data`, set `resp_hit` = 1, increment `hit_count`, go to RESP.
  - Otherwise: increment `miss_count` and go to MEM_REQ.
- MEM_REQ: `avm_read` = 1, `avm_address` = `addr_q`, both held stable while `avm_waitrequest` = 1. The first cycle with `avm_waitrequest` = 0 is the accepting cycle; go to MEM_WAIT.
- MEM_WAIT: wait for `avm_readdatavalid`. On it, latch `avm_readdata` into `resp_data` and `c_wdata`, set `resp_hit` = 0, go to FILL. No timeout.
- FILL (1 cycle): `c_en` = 1, `c_wrt` = 1, `c_addr` = `addr_q`, `c_wdata` = fetched word. Go to RESP.
- RESP: `resp_valid` = 1. `resp_data` and `resp_hit` are held stable until `resp_ready` = 1; on that edge go to IDLE.
- `c_en` is 0 in every state except LOOKUP and FILL. `avm_read` is 0 outside MEM_REQ.
- Counters increment by 1 and saturate at all-ones, with no wrap. Only `rst` clears them.
- A cache success with `c_rdata` is trusted as-is; the block never re-validates against memory.

## Timing
- Request accepted on edge E0 (IDLE, `req_valid` = 1):
  - LOOKUP during E0–E1.
  - CHECK during E1–E2.
  - On a hit, `resp_valid` is high from E2 onward, so hit latency is 2 cycles from acceptance to `resp_valid`.
- Miss with zero wait states and data arriving N ≥ 1 cycles after the read is accepted:
  - MEM_REQ from E2; read accepted at E3.
  - `avm_readdatavalid` at cycle E3+N-1; FILL the following cycle; `resp_valid` one cycle after FILL.
  - With N = 1 and no stall, `resp_valid` rises at E5.
- Back-to-back: the earliest next acceptance is the edge after the `resp_valid && resp_ready` edge, because IDLE is reentered first. `req_ready` is never high while `resp_valid` is high.
- `avm_readdatavalid` outside MEM_WAIT is ignored.
- Async reset mid-operation:
  - State goes to IDLE immediately and all outputs take reset values.
  - An outstanding memory read is abandoned, and its late `avm_readdatavalid` is ignored in IDLE.
  - If reset asserts during FILL, the cache write may be lost; the line then misses again later. This is acceptable.

## Test plan
- Cold miss then hit: read 0x000003 with memory returning 0x0000000F (waitrequest 0, N = 1).
  - First read: `resp_valid` at E5, `resp_data` = 0xF, `resp_hit` = 0, one FILL write of 0xF to address 3, `miss_count` = 1.
  - Re-read 0x000003: `resp_valid` 2 cycles after acceptance, `resp_hit` = 1, no `avm_read`, `hit_count` = 1.
- Waitrequest stall: miss on 0x000004 with `avm_waitrequest` high for 3 cycles → `avm_read` and `avm_address` = 0x000004 held stable for 4 cycles, exactly one read issued, data returned correctly.
- Index conflict: read 0x000005, then 0x000105 (same index, different tag), then 0x000005.
  - Expected: three misses, three fills, `miss_count` = 3.
  - Each response carries its own memory word, 0xD versus 0xC.
- Response backpressure: `resp_ready` low for 5 cycles on a hit → `resp_valid`, `resp_data` and `resp_hit` stable throughout, `req_ready` = 0, a new `req_valid` is not accepted.
- Reset mid-miss: assert `rst` during MEM_WAIT, then pulse a stray `avm_readdatavalid` with 0xDEAD.
  - Required: all outputs 0 and `req_ready` = 1 immediately, counters cleared.
  - No cache write and no `resp_valid` occur.
  - The next read of the same address misses.
- Counter saturation (CNT_W = 4): 17 hits to one address → `hit_count` stops at 0xF.
